// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read channel between the fetch controller and the memory.
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read, registered IF/ID outputs,
// branch redirects that squash in-flight reads.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCSrc,
   input  logic [31:0]        branch,
   input  logic               stall,
   fetch_ctrl_if.master       imem,
   output logic [31:0]        instrucao,
   output logic [31:0]        PC,
   output logic [31:0]        PC4,
   output logic               if_valid
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DELIVER = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_req, w_req_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_tgt, w_tgt_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_pc4, w_pc4_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_rst_done;
   logic [31:0] w_target;

   assign w_target = branch & ~32'h3;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_tgt      <= 32'h0;
         r_instr    <= 32'h0;
         r_pc       <= 32'h0;
         r_pc4      <= 32'h0;
         r_valid    <= 1'b0;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_addr     <= w_addr_nxt;
         r_tgt      <= w_tgt_nxt;
         r_instr    <= w_instr_nxt;
         r_pc       <= w_pc_nxt;
         r_pc4      <= w_pc4_nxt;
         r_valid    <= w_valid_nxt;
         r_rst_done <= 1'b1;
      end
   end

   // NOTE: every next-value gets a hold default up front so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_tgt_nxt   = r_tgt;
      w_instr_nxt = r_instr;
      w_pc_nxt    = r_pc;
      w_pc4_nxt   = r_pc4;
      w_valid_nxt = r_valid;

      case (r_state)
         S_IDLE: begin
            w_req_nxt = 1'b0;
            if (PCSrc) begin
               w_addr_nxt  = w_target;
               w_valid_nxt = 1'b0;
            end
            // One dwell cycle after reset so the first request lands on the second edge.
            if (r_rst_done) begin
               w_state_nxt = S_FETCH;
               w_req_nxt   = 1'b1;
            end
         end
         S_FETCH: begin
            w_req_nxt = 1'b1;
            if (imem.imem_ack) begin
               if (PCSrc) begin
                  w_addr_nxt = w_target;
               end else begin
                  w_instr_nxt = imem.imem_rdata;
                  w_pc_nxt    = r_addr;
                  w_pc4_nxt   = r_addr + 32'd4;
                  w_valid_nxt = 1'b1;
                  w_req_nxt   = 1'b0;
                  w_state_nxt = S_DELIVER;
               end
            end else if (PCSrc) begin
               w_tgt_nxt   = w_target;
               w_state_nxt = S_DISCARD;
            end
         end
         S_DELIVER: begin
            w_req_nxt = 1'b0;
            if (PCSrc) begin
               w_addr_nxt  = w_target;
               w_valid_nxt = 1'b0;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_FETCH;
            end else if (!stall) begin
               w_addr_nxt  = r_pc4;
               w_valid_nxt = 1'b0;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_DISCARD: begin
            w_req_nxt = 1'b1;
            if (PCSrc) w_tgt_nxt = w_target;
            if (imem.imem_ack) begin
               w_addr_nxt  = PCSrc ? w_target : r_tgt;
               w_state_nxt = S_FETCH;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_addr;
   assign instrucao      = r_instr;
   assign PC             = r_pc;
   assign PC4            = r_pc4;
   assign if_valid       = r_valid;

endmodule
